// File: rtl/acc_pkg.sv
// Shared accelerator constants and types.
// Used by the conv address generator and acc_top.
package acc_pkg;

  localparam int ADDR_W     = 13;
  localparam int SRAM_DEPTH = 1 << ADDR_W;
  localparam int KERNEL     = 3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_W_LSB  = 8;
  localparam int CTRL_H_LSB  = 16;
  localparam int CTRL_CW_LSB = 24;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // W*CW via shift-and-add over the 4 CW bits.
  function automatic logic [ADDR_W-1:0] row_stride(
    input logic [7:0] w,
    input logic [3:0] cw
  );
    logic [ADDR_W-1:0] acc;
    logic [ADDR_W-1:0] ws;
    acc = '0;
    ws  = ADDR_W'(w);
    for (int i = 0; i < 4; i++) begin
      if (cw[i]) acc = acc + (ws << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/conv_addr_gen_if.sv
// Control, config and SRAM/MAC strobe bundle
// of the conv address generator.
interface conv_addr_gen_if;
  import acc_pkg::*;

  logic              start;
  logic              abort;
  logic              hold;
  logic [7:0]        cfg_w;
  logic [7:0]        cfg_h;
  logic [3:0]        cfg_cw;
  logic [ADDR_W-1:0] cfg_ifm_base;
  logic [ADDR_W-1:0] cfg_wht_base;
  logic [ADDR_W-1:0] cfg_res_base;
  logic              ifm_cs;
  logic              wht_cs;
  logic [ADDR_W-1:0] ifm_addr;
  logic [ADDR_W-1:0] wht_addr;
  logic              mac_valid;
  logic              mac_first;
  logic              mac_last;
  logic              res_we;
  logic [ADDR_W-1:0] res_addr;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, abort, hold,
    input  cfg_w, cfg_h, cfg_cw,
    input  cfg_ifm_base, cfg_wht_base,
    input  cfg_res_base,
    output ifm_cs, wht_cs,
    output ifm_addr, wht_addr,
    output mac_valid, mac_first, mac_last,
    output res_we, res_addr,
    output busy, done, err
  );

  modport slave (
    output start, abort, hold,
    output cfg_w, cfg_h, cfg_cw,
    output cfg_ifm_base, cfg_wht_base,
    output cfg_res_base,
    input  ifm_cs, wht_cs,
    input  ifm_addr, wht_addr,
    input  mac_valid, mac_first, mac_last,
    input  res_we, res_addr,
    input  busy, done, err
  );

endinterface

// File: rtl/tap_delay_line.sv
// Fixed-depth valid+data shift register
// with synchronous clear.
module tap_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];

  // Shift; data is zeroed in empty slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else if (clr) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      d[0] <= in_valid ? in_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        v[i] <= v[i-1];
        d[i] <= d[i-1];
      end
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

endmodule

// File: rtl/conv_addr_gen.sv
// 3x3 stride-1 conv sequencer: walks IFM and
// weight SRAMs one tap per cycle.
module conv_addr_gen #(
  parameter int MAC_LAT = 2
) (
  input logic             clk,
  input logic             rst_n,
  conv_addr_gen_if.master bus
);
  import acc_pkg::*;

  localparam int DW = $clog2(MAC_LAT + 1) + 1;
  localparam logic [1:0] KL = 2'(KERNEL - 1);

  state_t            state;
  logic              err_q;
  logic [7:0]        wm3, hm3, ox, oy;
  logic [3:0]        cwm1, c;
  logic [1:0]        kx, ky;
  logic [ADDR_W-1:0] stride, cwa, wbase;
  logic [ADDR_W-1:0] ifm, wht, krow, pix, prow;
  logic [ADDR_W-1:0] raddr;
  logic [DW-1:0]     dcnt;
  logic              issue, bad_cfg;
  logic              tap_first, pix_last, all_last;
  logic [1:0]        mac_flags;

  assign issue = (state == S_RUN) && !bus.hold;
  assign bad_cfg = (bus.cfg_w < 8'd3)
                || (bus.cfg_h < 8'd3)
                || (bus.cfg_cw == 4'd0);
  assign tap_first = (c == 4'd0) && (kx == 2'd0)
                  && (ky == 2'd0);
  assign pix_last = (c == cwm1) && (kx == KL)
                 && (ky == KL);
  assign all_last = pix_last && (ox == wm3)
                 && (oy == hm3);

  assign bus.ifm_cs   = issue;
  assign bus.wht_cs   = issue;
  assign bus.ifm_addr = ifm;
  assign bus.wht_addr = wht;
  assign bus.busy = (state == S_RUN)
                 || (state == S_DRAIN);
  assign bus.done = (state == S_DONE);
  assign bus.err  = err_q;

  // Sequencer FSM and tap loop counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      err_q <= 1'b0;
      wm3 <= '0; hm3 <= '0; cwm1 <= '0;
      ox <= '0; oy <= '0; c <= '0;
      kx <= '0; ky <= '0;
      stride <= '0; cwa <= '0; wbase <= '0;
      ifm <= '0; wht <= '0; krow <= '0;
      pix <= '0; prow <= '0; raddr <= '0;
      dcnt <= '0;
    end else if (bus.abort) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (bus.start) begin
          err_q <= bad_cfg;
          if (bad_cfg) begin
            state <= S_DONE;
          end else begin
            state  <= S_RUN;
            wm3    <= bus.cfg_w - 8'd3;
            hm3    <= bus.cfg_h - 8'd3;
            cwm1   <= bus.cfg_cw - 4'd1;
            cwa    <= ADDR_W'(bus.cfg_cw);
            stride <= row_stride(bus.cfg_w,
                                 bus.cfg_cw);
            wbase  <= bus.cfg_wht_base;
            ox <= '0; oy <= '0; c <= '0;
            kx <= '0; ky <= '0;
            ifm  <= bus.cfg_ifm_base;
            krow <= bus.cfg_ifm_base;
            pix  <= bus.cfg_ifm_base;
            prow <= bus.cfg_ifm_base;
            wht  <= bus.cfg_wht_base;
            raddr <= bus.cfg_res_base;
          end
        end
        S_RUN: if (issue) begin
          if (all_last) begin
            state <= S_DRAIN;
            dcnt  <= '0;
          end else if (c != cwm1) begin
            c   <= c + 4'd1;
            ifm <= ifm + 1'b1;
            wht <= wht + 1'b1;
          end else if (kx != KL) begin
            c   <= '0;
            kx  <= kx + 2'd1;
            ifm <= ifm + 1'b1;
            wht <= wht + 1'b1;
          end else if (ky != KL) begin
            c    <= '0;
            kx   <= '0;
            ky   <= ky + 2'd1;
            ifm  <= krow + stride;
            krow <= krow + stride;
            wht  <= wht + 1'b1;
          end else begin
            c <= '0; kx <= '0; ky <= '0;
            wht   <= wbase;
            raddr <= raddr + 1'b1;
            if (ox != wm3) begin
              ox   <= ox + 8'd1;
              ifm  <= pix + cwa;
              krow <= pix + cwa;
              pix  <= pix + cwa;
            end else begin
              ox   <= '0;
              oy   <= oy + 8'd1;
              ifm  <= prow + stride;
              krow <= prow + stride;
              pix  <= prow + stride;
              prow <= prow + stride;
            end
          end
        end
        S_DRAIN: begin
          if (dcnt == DW'(MAC_LAT)) state <= S_DONE;
          else dcnt <= dcnt + DW'(1);
        end
        S_DONE: state <= S_IDLE;
      endcase
    end
  end

  tap_delay_line #(
    .DEPTH(1),
    .WIDTH(2)
  ) u_mac_dly (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (bus.abort),
    .in_valid (issue),
    .in_data  ({tap_first, pix_last}),
    .out_valid(bus.mac_valid),
    .out_data (mac_flags)
  );

  assign bus.mac_first = mac_flags[1];
  assign bus.mac_last  = mac_flags[0];

  tap_delay_line #(
    .DEPTH(1 + MAC_LAT),
    .WIDTH(ADDR_W)
  ) u_res_dly (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (bus.abort),
    .in_valid (issue && pix_last),
    .in_data  (raddr),
    .out_valid(bus.res_we),
    .out_data (bus.res_addr)
  );

endmodule

// File: tb/tb_conv_addr_gen.sv
// Self-checking bench for conv_addr_gen:
// table vectors, corner sequences, random runs.
module tb_conv_addr_gen;
  import acc_pkg::*;

  localparam int MAC_LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_addr_gen_if bus();

  conv_addr_gen #(.MAC_LAT(MAC_LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_run = 0;
  int n_fail = 0;

  typedef struct {
    int w, h, cw, ib, wb, rb;
    int hlo, hhi, abt, poke;
    int x_taps, x_done, x_err;
  } vec_t;

  typedef struct {
    int ia, wa, f, l, cyc;
  } ev_t;

  task automatic check(input string nm,
                       input int got,
                       input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               nm, got, got, exp, exp);
    end
  endtask

  task automatic run(input string tag, input vec_t v);
    ev_t et[$];
    ev_t er[$];
    ev_t gt[$];
    ev_t gm[$];
    ev_t gr[$];
    int  gd[$];
    ev_t e;
    int  bad, cyc, xdone, bend, limit;
    int  busy_bad, cs_bad, nm;
    bad = (v.w < 3 || v.h < 3 || v.cw == 0) ? 1 : 0;
    cyc = 1;
    if (bad == 0) begin
      for (int oy = 0; oy < v.h - 2; oy++)
      for (int ox = 0; ox < v.w - 2; ox++)
      for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++)
      for (int c = 0; c < v.cw; c++) begin
        while (v.hlo > 0 && cyc >= v.hlo && cyc <= v.hhi)
          cyc++;
        e.ia = (v.ib + ((oy + ky) * v.w + ox + kx) * v.cw + c)
               % SRAM_DEPTH;
        e.wa = (v.wb + (ky * 3 + kx) * v.cw + c) % SRAM_DEPTH;
        e.f = (ky == 0 && kx == 0 && c == 0) ? 1 : 0;
        e.l = (ky == 2 && kx == 2 && c == v.cw - 1) ? 1 : 0;
        e.cyc = cyc;
        cyc++;
        if (v.abt == 0 || e.cyc <= v.abt) et.push_back(e);
        if (e.l == 1) begin
          e.ia = (v.rb + oy * (v.w - 2) + ox) % SRAM_DEPTH;
          e.cyc = e.cyc + 1 + MAC_LAT;
          if (v.abt == 0 || e.cyc <= v.abt) er.push_back(e);
        end
      end
    end
    if (v.abt > 0) xdone = 0;
    else if (bad == 1) xdone = 1;
    else xdone = cyc - 1 + 2 + MAC_LAT;
    if (v.abt > 0) bend = v.abt;
    else if (bad == 1) bend = 0;
    else bend = xdone - 1;
    limit = (v.abt > 0) ? v.abt + 8 : xdone + 4;

    @(posedge clk); #1;
    bus.cfg_w = 8'(v.w);
    bus.cfg_h = 8'(v.h);
    bus.cfg_cw = 4'(v.cw);
    bus.cfg_ifm_base = ADDR_W'(v.ib);
    bus.cfg_wht_base = ADDR_W'(v.wb);
    bus.cfg_res_base = ADDR_W'(v.rb);
    bus.start = 1'b1;
    bus.hold = 1'b0;
    bus.abort = 1'b0;
    busy_bad = 0;
    cs_bad = 0;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      bus.start = (k == v.poke);
      bus.hold = (v.hlo > 0 && k >= v.hlo && k <= v.hhi);
      bus.abort = (k == v.abt);
      if (k == 1) begin
        bus.cfg_w = 8'($urandom);
        bus.cfg_h = 8'($urandom);
        bus.cfg_cw = 4'($urandom);
        bus.cfg_ifm_base = ADDR_W'($urandom);
        bus.cfg_wht_base = ADDR_W'($urandom);
        bus.cfg_res_base = ADDR_W'($urandom);
      end
      @(negedge clk);
      if (bus.ifm_cs !== bus.wht_cs) cs_bad++;
      if (bus.busy !== (k <= bend)) busy_bad++;
      if (bus.ifm_cs === 1'b1) begin
        e.ia = int'(bus.ifm_addr);
        e.wa = int'(bus.wht_addr);
        e.cyc = k;
        gt.push_back(e);
      end
      if (bus.mac_valid === 1'b1) begin
        e.f = int'(bus.mac_first);
        e.l = int'(bus.mac_last);
        e.cyc = k;
        gm.push_back(e);
      end
      if (bus.res_we === 1'b1) begin
        e.ia = int'(bus.res_addr);
        e.cyc = k;
        gr.push_back(e);
      end
      if (bus.done === 1'b1) gd.push_back(k);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.hold = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);

    check({tag, ".cs_pair"}, cs_bad, 0);
    check({tag, ".busy_bad_cycles"}, busy_bad, 0);
    check({tag, ".err"}, int'(bus.err),
          (v.x_err >= 0) ? v.x_err : bad);
    check({tag, ".ntaps"}, gt.size(), et.size());
    if (v.x_taps >= 0)
      check({tag, ".ntaps_spec"}, gt.size(), v.x_taps);
    for (int i = 0; i < gt.size() && i < et.size(); i++) begin
      check($sformatf("%s.ifm[%0d]", tag, i), gt[i].ia, et[i].ia);
      check($sformatf("%s.wht[%0d]", tag, i), gt[i].wa, et[i].wa);
      check($sformatf("%s.cyc[%0d]", tag, i), gt[i].cyc, et[i].cyc);
    end
    nm = 0;
    foreach (et[i])
      if (v.abt == 0 || et[i].cyc + 1 <= v.abt) nm++;
    check({tag, ".nmac"}, gm.size(), nm);
    for (int i = 0; i < gm.size() && i < nm; i++) begin
      check($sformatf("%s.mcyc[%0d]", tag, i),
            gm[i].cyc, et[i].cyc + 1);
      check($sformatf("%s.mfirst[%0d]", tag, i), gm[i].f, et[i].f);
      check($sformatf("%s.mlast[%0d]", tag, i), gm[i].l, et[i].l);
    end
    check({tag, ".nres"}, gr.size(), er.size());
    for (int i = 0; i < gr.size() && i < er.size(); i++) begin
      check($sformatf("%s.raddr[%0d]", tag, i), gr[i].ia, er[i].ia);
      check($sformatf("%s.rcyc[%0d]", tag, i), gr[i].cyc, er[i].cyc);
    end
    check({tag, ".ndone"}, gd.size(), (xdone > 0) ? 1 : 0);
    if (gd.size() > 0 && xdone > 0)
      check({tag, ".done_cyc"}, gd[0], xdone);
    if (v.x_done >= 0)
      check({tag, ".done_spec"},
            (gd.size() > 0) ? gd[0] : 0, v.x_done);
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    tbl[0] = '{4, 4, 1, 0, 0, 0, 0, 0, 0, 0, 36, 40, 0};
    tbl[1] = '{5, 3, 2, 'h100, 0, 'h1F00,
               0, 0, 0, 0, 54, 58, 0};
    tbl[2] = '{4, 4, 1, 0, 0, 0, 5, 7, 0, 0, 36, 43, 0};
    tbl[3] = '{2, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[4] = '{4, 4, 1, 0, 0, 0, 0, 0, 0, 3, 36, 40, 0};
    tbl[5] = '{4, 4, 1, 0, 0, 0, 0, 0, 20, 0, 20, 0, 0};
    tbl[6] = '{4, 4, 1, 0, 0, 0, 0, 0, 0, 0, 36, 40, 0};
    tbl[7] = '{3, 3, 1, 'h1FFE, 'h1FFC, 'h1FFF,
               0, 0, 0, 0, 9, 13, 0};
    tbl[8] = '{5, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[9] = '{3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.hold = 1'b0;
    bus.cfg_w = '0;
    bus.cfg_h = '0;
    bus.cfg_cw = '0;
    bus.cfg_ifm_base = '0;
    bus.cfg_wht_base = '0;
    bus.cfg_res_base = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.ifm_cs", int'(bus.ifm_cs), 0);
    check("rst.wht_cs", int'(bus.wht_cs), 0);
    check("rst.ifm_addr", int'(bus.ifm_addr), 0);
    check("rst.wht_addr", int'(bus.wht_addr), 0);
    check("rst.mac_valid", int'(bus.mac_valid), 0);
    check("rst.mac_first", int'(bus.mac_first), 0);
    check("rst.mac_last", int'(bus.mac_last), 0);
    check("rst.res_we", int'(bus.res_we), 0);
    check("rst.res_addr", int'(bus.res_addr), 0);
    check("rst.busy", int'(bus.busy), 0);
    check("rst.done", int'(bus.done), 0);
    check("rst.err", int'(bus.err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run($sformatf("vec%0d", i), tbl[i]);

    // abort and start together in IDLE: abort wins
    @(posedge clk); #1;
    bus.cfg_w = 8'd4;
    bus.cfg_h = 8'd4;
    bus.cfg_cw = 4'd1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    check("abst.busy", int'(bus.busy), 0);
    check("abst.ifm_cs", int'(bus.ifm_cs), 0);
    check("abst.err", int'(bus.err), 1);
    @(negedge clk);
    check("abst.busy2", int'(bus.busy), 0);
    check("abst.done", int'(bus.done), 0);

    run("clr", tbl[0]);

    for (int r = 0; r < 6; r++) begin
      rv.w = $urandom_range(3, 7);
      rv.h = $urandom_range(3, 6);
      rv.cw = $urandom_range(1, 3);
      rv.ib = $urandom_range(0, SRAM_DEPTH - 1);
      rv.wb = $urandom_range(0, SRAM_DEPTH - 1);
      rv.rb = $urandom_range(0, SRAM_DEPTH - 1);
      rv.hlo = ($urandom_range(0, 1) == 1)
               ? $urandom_range(2, 12) : 0;
      rv.hhi = rv.hlo + $urandom_range(0, 3);
      rv.abt = 0;
      rv.poke = ($urandom_range(0, 1) == 1) ? 2 : 0;
      rv.x_taps = -1;
      rv.x_done = -1;
      rv.x_err = -1;
      run($sformatf("rnd%0d", r), rv);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
